// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and completion signals shared between the
// arbiter (slave side) and its environment (master side).
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              m_read;
   logic              m_write;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              m_done;
   logic              m_err;

   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic [DATA_W-1:0] f_rdata;
   logic              f_done;
   logic              f_err;

   logic              mem_ce;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  m_read, m_write, m_addr, m_wdata, f_req, f_addr, mem_rdata, mem_ack,
      output m_rdata, m_done, m_err, f_rdata, f_done, f_err,
             mem_ce, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output m_read, m_write, m_addr, m_wdata, f_req, f_addr, mem_rdata, mem_ack,
      input  m_rdata, m_done, m_err, f_rdata, f_done, f_err,
             mem_ce, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory: M stage has priority,
// bounded by a starvation limit for fetch; variable-latency ack with timeout.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 15,
   parameter int MAX_STREAK = 4
) (
   input logic            clk,
   input logic            rst,
   mem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic {OWN_M, OWN_F} owner_t;

   localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic [7:0]        timeoutCnt_q, timeoutCnt_d;
   logic [3:0]        streak_q, streak_d;
   logic              memCe_q, memCe_d;
   logic              memWe_q, memWe_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [DATA_W-1:0] memWdata_q, memWdata_d;
   logic [DATA_W-1:0] mRdata_q, mRdata_d;
   logic              mDone_q, mDone_d;
   logic              mErr_q, mErr_d;
   logic [DATA_W-1:0] fRdata_q, fRdata_d;
   logic              fDone_q, fDone_d;
   logic              fErr_q, fErr_d;

   logic mReq;
   logic grantM;
   logic busyEnd;
   logic busyErr;

   // Fetch wins only when it has already watched MAX_STREAK M grants go by.
   assign mReq    = bus.m_read | bus.m_write;
   assign grantM  = mReq && !(bus.f_req && (streak_q == STREAK_MAX));
   assign busyEnd = bus.mem_ack || (timeoutCnt_q == TO_LAST);
   assign busyErr = !bus.mem_ack;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      timeoutCnt_d = timeoutCnt_q;
      streak_d     = streak_q;
      memCe_d      = memCe_q;
      memWe_d      = memWe_q;
      memAddr_d    = memAddr_q;
      memWdata_d   = memWdata_q;
      mRdata_d     = mRdata_q;
      mDone_d      = 1'b0;
      mErr_d       = mErr_q;
      fRdata_d     = fRdata_q;
      fDone_d      = 1'b0;
      fErr_d       = fErr_q;

      case (state_q)
         IDLE: begin
            if (grantM) begin
               state_d      = BUSY;
               owner_d      = OWN_M;
               timeoutCnt_d = 8'd0;
               memCe_d      = 1'b1;
               memWe_d      = bus.m_write;
               memAddr_d    = bus.m_addr;
               memWdata_d   = bus.m_wdata;
               if (bus.f_req) begin
                  streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
               end else begin
                  streak_d = 4'd0;
               end
            end else if (bus.f_req) begin
               state_d      = BUSY;
               owner_d      = OWN_F;
               timeoutCnt_d = 8'd0;
               memCe_d      = 1'b1;
               memWe_d      = 1'b0;
               memAddr_d    = bus.f_addr;
               memWdata_d   = '0;
               streak_d     = 4'd0;
            end
         end

         BUSY: begin
            if (busyEnd) begin
               state_d = DONE;
               memCe_d = 1'b0;
               memWe_d = 1'b0;
               if (owner_q == OWN_M) begin
                  mDone_d = 1'b1;
                  mErr_d  = busyErr;
                  if (!busyErr && !memWe_q) begin
                     mRdata_d = bus.mem_rdata;
                  end
               end else begin
                  fDone_d = 1'b1;
                  fErr_d  = busyErr;
                  if (!busyErr) begin
                     fRdata_d = bus.mem_rdata;
                  end
               end
            end else begin
               timeoutCnt_d = timeoutCnt_q + 8'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_M;
         timeoutCnt_q <= 8'd0;
         streak_q     <= 4'd0;
         memCe_q      <= 1'b0;
         memWe_q      <= 1'b0;
         memAddr_q    <= '0;
         memWdata_q   <= '0;
         mRdata_q     <= '0;
         mDone_q      <= 1'b0;
         mErr_q       <= 1'b0;
         fRdata_q     <= '0;
         fDone_q      <= 1'b0;
         fErr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         timeoutCnt_q <= timeoutCnt_d;
         streak_q     <= streak_d;
         memCe_q      <= memCe_d;
         memWe_q      <= memWe_d;
         memAddr_q    <= memAddr_d;
         memWdata_q   <= memWdata_d;
         mRdata_q     <= mRdata_d;
         mDone_q      <= mDone_d;
         mErr_q       <= mErr_d;
         fRdata_q     <= fRdata_d;
         fDone_q      <= fDone_d;
         fErr_q       <= fErr_d;
      end
   end

   assign bus.mem_ce    = memCe_q;
   assign bus.mem_we    = memWe_q;
   assign bus.mem_addr  = memAddr_q;
   assign bus.mem_wdata = memWdata_q;
   assign bus.m_rdata   = mRdata_q;
   assign bus.m_done    = mDone_q;
   assign bus.m_err     = mErr_q;
   assign bus.f_rdata   = fRdata_q;
   assign bus.f_done    = fDone_q;
   assign bus.f_err     = fErr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected completions,
// a negedge monitor pops and compares them against every done pulse.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [31:0] KEY = 32'h5A5A_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15), .MAX_STREAK(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          isF;
      logic [31:0] rdata;
      bit          err;
   } expT;

   expT         sbQ[$];
   expT         monExp;
   int          checks = 0;
   int          passes = 0;
   bit          ackEnable = 1'b0;
   int          ackWait = 0;
   int          memWaitCnt = 0;
   bit          overrideEn = 1'b0;
   logic [31:0] overrideData = '0;
   bit          prevMDone = 1'b0;
   bit          prevFDone = 1'b0;
   int          cyc;
   int          doneCnt;
   int          ceCycles;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   task automatic applyStimulus(input bit mRead, input bit mWrite,
                                input logic [31:0] mAddr, input logic [31:0] mWdata,
                                input bit fReq, input logic [31:0] fAddr);
      bus.m_read  = mRead;
      bus.m_write = mWrite;
      bus.m_addr  = mAddr;
      bus.m_wdata = mWdata;
      bus.f_req   = fReq;
      bus.f_addr  = fAddr;
   endtask

   task automatic waitDone(input bit isF, input int budget, output int cycles);
      cycles = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cycles++;
         if (isF ? bus.f_done : bus.m_done) return;
      end
      checks++;
      $display("[TB] FAIL waitDone: no %s done within %0d cycles", isF ? "f" : "m", budget);
   endtask

   task automatic pushExp(input bit isF, input logic [31:0] rdata, input bit err);
      expT e;
      e.isF   = isF;
      e.rdata = rdata;
      e.err   = err;
      sbQ.push_back(e);
   endtask

   // Memory model: acks after ackWait idle cycles, data is address ^ KEY unless overridden.
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!bus.mem_ce || !ackEnable) begin
            bus.mem_ack = 1'b0;
            memWaitCnt  = 0;
         end else if (memWaitCnt >= ackWait) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = overrideEn ? overrideData : (bus.mem_addr ^ KEY);
         end else begin
            bus.mem_ack = 1'b0;
            memWaitCnt++;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (bus.m_done && bus.f_done) begin
            checks++;
            $display("[TB] FAIL doneExclusive: m_done=%0b f_done=%0b, required at most one", bus.m_done, bus.f_done);
         end else if (bus.m_done || bus.f_done) begin
            if (sbQ.size() == 0) begin
               checks++;
               $display("[TB] FAIL unexpectedDone: m_done=%0b f_done=%0b with nothing outstanding", bus.m_done, bus.f_done);
            end else begin
               monExp = sbQ.pop_front();
               checkOutput("donePort", 32'(bus.f_done), 32'(monExp.isF));
               if (bus.f_done) begin
                  checkOutput("f_rdata", bus.f_rdata, monExp.rdata);
                  checkOutput("f_err", 32'(bus.f_err), 32'(monExp.err));
               end else begin
                  checkOutput("m_rdata", bus.m_rdata, monExp.rdata);
                  checkOutput("m_err", 32'(bus.m_err), 32'(monExp.err));
               end
            end
         end
         if ((bus.m_done && prevMDone) || (bus.f_done && prevFDone)) begin
            checks++;
            $display("[TB] FAIL donePulseWidth: done high for 2 cycles, required 1");
         end
         prevMDone = bus.m_done;
         prevFDone = bus.f_done;
      end
   end

   initial begin
      applyStimulus(0, 0, '0, '0, 0, '0);
      repeat (3) @(negedge clk);
      checkOutput("rst mem_ce", 32'(bus.mem_ce), 32'd0);
      checkOutput("rst mem_we", 32'(bus.mem_we), 32'd0);
      checkOutput("rst mem_addr", bus.mem_addr, 32'd0);
      checkOutput("rst dones", {30'd0, bus.m_done, bus.f_done}, 32'd0);
      checkOutput("rst errs", {30'd0, bus.m_err, bus.f_err}, 32'd0);
      checkOutput("rst m_rdata", bus.m_rdata, 32'd0);
      checkOutput("rst f_rdata", bus.f_rdata, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      $display("[TB] reset during BUSY");
      ackEnable = 1'b0;
      applyStimulus(0, 1, 32'h40, 32'h1111_2222, 0, '0);
      @(negedge clk);
      checkOutput("t1 ce inflight", 32'(bus.mem_ce), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 0, '0, '0, 0, '0);
      #1;
      checkOutput("t1 ce async", 32'(bus.mem_ce), 32'd0);
      checkOutput("t1 we async", 32'(bus.mem_we), 32'd0);
      checkOutput("t1 dones async", {30'd0, bus.m_done, bus.f_done}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("t1 idle after reset", 32'(bus.mem_ce), 32'd0);

      $display("[TB] M read zero-wait");
      ackEnable    = 1'b1;
      ackWait      = 0;
      overrideEn   = 1'b1;
      overrideData = 32'hDEAD_BEEF;
      pushExp(0, 32'hDEAD_BEEF, 0);
      applyStimulus(1, 0, 32'h10, '0, 0, '0);
      @(negedge clk);
      checkOutput("t2 ce", 32'(bus.mem_ce), 32'd1);
      checkOutput("t2 addr", bus.mem_addr, 32'h10);
      checkOutput("t2 we", 32'(bus.mem_we), 32'd0);
      waitDone(0, 20, cyc);
      checkOutput("t2 latency", 32'(cyc), 32'd1);
      applyStimulus(0, 0, '0, '0, 0, '0);
      overrideEn = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] M write and fetch together");
      pushExp(0, 32'hDEAD_BEEF, 0);
      pushExp(1, 32'h5A5A_0100, 0);
      applyStimulus(0, 1, 32'h20, 32'h1234_5678, 1, 32'h100);
      @(negedge clk);
      checkOutput("t3 m we", 32'(bus.mem_we), 32'd1);
      checkOutput("t3 m wdata", bus.mem_wdata, 32'h1234_5678);
      checkOutput("t3 m addr", bus.mem_addr, 32'h20);
      waitDone(0, 20, cyc);
      applyStimulus(0, 0, '0, '0, 1, 32'h100);
      repeat (2) @(negedge clk);
      checkOutput("t3 f ce", 32'(bus.mem_ce), 32'd1);
      checkOutput("t3 f we", 32'(bus.mem_we), 32'd0);
      checkOutput("t3 f addr", bus.mem_addr, 32'h100);
      checkOutput("t3 f wdata", bus.mem_wdata, 32'd0);
      waitDone(1, 20, cyc);
      applyStimulus(0, 0, '0, '0, 0, '0);
      repeat (2) @(negedge clk);

      $display("[TB] starvation limit");
      for (int i = 0; i < 10; i++) begin
         if ((i % 5) == 4) pushExp(1, 32'h5A5A_0200, 0);
         else              pushExp(0, 32'hDEAD_BEEF, 0);
      end
      applyStimulus(1, 1, 32'h300, 32'h0BAD_F00D, 1, 32'h200);
      @(negedge clk);
      checkOutput("t4 rw is write", 32'(bus.mem_we), 32'd1);
      checkOutput("t4 wdata", bus.mem_wdata, 32'h0BAD_F00D);
      doneCnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.m_done || bus.f_done) doneCnt++;
         if (doneCnt == 10) break;
      end
      checkOutput("t4 done count", 32'(doneCnt), 32'd10);
      applyStimulus(0, 0, '0, '0, 0, '0);
      repeat (2) @(negedge clk);

      $display("[TB] fetch timeout");
      ackEnable = 1'b0;
      pushExp(1, 32'h5A5A_0200, 1);
      applyStimulus(0, 0, '0, '0, 1, 32'h400);
      ceCycles = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.mem_ce) ceCycles++;
         else break;
      end
      checkOutput("t5 ce cycles", 32'(ceCycles), 32'd15);
      checkOutput("t5 f_done", 32'(bus.f_done), 32'd1);
      applyStimulus(0, 0, '0, '0, 0, '0);
      repeat (3) @(negedge clk);
      checkOutput("t5 f_err hold", 32'(bus.f_err), 32'd1);
      checkOutput("t5 f_rdata hold", bus.f_rdata, 32'h5A5A_0200);
      ackEnable = 1'b1;

      $display("[TB] M write dropped during BUSY");
      ackWait = 3;
      pushExp(0, 32'hDEAD_BEEF, 0);
      applyStimulus(0, 1, 32'h500, 32'hA1B2_C3D4, 0, '0);
      @(negedge clk);
      checkOutput("t6 ce", 32'(bus.mem_ce), 32'd1);
      checkOutput("t6 we", 32'(bus.mem_we), 32'd1);
      applyStimulus(0, 0, '0, '0, 0, '0);
      waitDone(0, 20, cyc);
      checkOutput("t6 latency", 32'(cyc), 32'd4);
      repeat (5) @(negedge clk);
      checkOutput("t6 no regrant", 32'(bus.mem_ce), 32'd0);
      checkOutput("t6 f_err still held", 32'(bus.f_err), 32'd1);
      ackWait = 0;

      checkOutput("scoreboard empty", 32'(sbQ.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data/instruction memory between two requesters: the fetch stage (read-only) and the memory stage (read/write, driven from the M-stage memory control signals).
- Serialises requests and owns the memory handshake, including variable-latency ack.
- Returns data with a one-cycle done pulse and flags a timeout error, which the pipeline maps to an address-error status.
- The memory stage has priority, bounded by a starvation limit so fetch always progresses.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, memory data width.
- TIMEOUT, 15, cycles in BUSY without mem_ack before the transaction is aborted with error (1..255).
- MAX_STREAK, 4, consecutive M grants allowed while f_req is pending before fetch is forced (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- m_read  in  1  M-stage read request, level, held until m_done.
- m_write  in  1  M-stage write request, level, held until m_done.
- m_addr  in  ADDR_W  M-stage address.
- m_wdata  in  DATA_W  M-stage write data.
- m_rdata  out  DATA_W  M-stage read data, valid with m_done.
- m_done  out  1  one-cycle completion pulse to the M stage.
- m_err  out  1  timeout flag, valid with m_done.
- f_req  in  1  fetch read request, level, held until f_done.
- f_addr  in  ADDR_W  fetch address.
- f_rdata  out  DATA_W  fetch read data, valid with f_done.
- f_done  out  1  one-cycle completion pulse to fetch.
- f_err  out  1  timeout flag, valid with f_done.
- mem_ce  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack = 1.
- mem_ack  in  1  memory completion, sampled while mem_ce = 1.

Behaviour:
- All outputs are registered.
- Reset (rst = 0, asynchronous, any time including mid-transaction):
  - state = IDLE; all outputs 0; streak counter and timeout counter = 0.
  - An in-flight transaction is dropped without a done pulse.
- FSM states: IDLE, BUSY, DONE.
- IDLE, arbitration on each rising edge:
  - M requests when m_read | m_write.
  - Grant M if M requests and NOT (f_req and streak == MAX_STREAK).
  - Otherwise grant F if f_req.
  - Otherwise stay in IDLE.
  - On any grant, latch owner, address, write data and we, and go to BUSY.
- Write-enable rule: mem_we = m_write. If m_read and m_write are both 1, the access is a write; m_rdata is unchanged.
- Streak counter:
  - +1 on an M grant while f_req = 1.
  - Cleared on an F grant, or on an M grant with f_req = 0.
  - Saturates at MAX_STREAK.
- BUSY:
  - mem_ce = 1 and mem_addr/mem_we/mem_wdata are stable for the whole state.
  - Fetch grants drive mem_we = 0, mem_wdata = 0.
  - mem_ack sampled 1: capture mem_rdata into the owner's rdata (reads only), err = 0, go to DONE. The timeout counter is cleared on entry to BUSY and incremented each cycle.
  - Counter reaches TIMEOUT without ack: err = 1, rdata unchanged, go to DONE.
  - mem_ce drops to 0 on the transition into DONE.
- DONE, exactly one cycle:
  - The owner's done = 1 and err is valid.
  - No arbitration in DONE. This gap lets the requester drop or change its request before the next IDLE sample.
  - Next state is IDLE.
- Hold rules: rdata holds until the next completion for that port. err holds until the next done of that port.
- Latency: request seen at edge 0 (IDLE) -> mem_ce = 1 from edge 0; zero-wait ack at edge 1 -> done high from edge 1 to edge 2.
  - Minimum 2 cycles per transaction; back-to-back issue every 3 cycles.
- A requester deasserting its request while BUSY does not abort the transaction; the done pulse is still generated.
- At most one of m_done / f_done is high in any cycle.

Test Plan:
- Reset mid-BUSY: M write in flight, rst = 0 for 1 cycle -> mem_ce, m_done, f_done = 0 immediately; state IDLE; no done pulse after release.
- M read at address 0x00000010, mem_ack at edge 1 with mem_rdata 0xDEADBEEF -> m_done pulse 1 cycle, m_rdata = 0xDEADBEEF, m_err = 0; f_done stays 0.
- m_write and f_req asserted together in IDLE (addr 0x20, data 0x12345678) -> M granted first (mem_we = 1, mem_wdata = 0x12345678); fetch granted in the following IDLE.
- m_read, m_write and f_req all held high with MAX_STREAK = 4, zero-wait memory -> grant order M, M, M, M, F, M, ...; fetch never waits more than 4 M transactions.
- No mem_ack for fetch, TIMEOUT = 15 -> mem_ce high 15 cycles then low; f_done = 1 with f_err = 1; f_rdata keeps its previous value.
- M write request dropped during BUSY with ack after 3 wait cycles -> write still completes, m_done pulses once, next IDLE grants nothing.
